div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/cpu_defines.sv | 24 ++
 rtl/div_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cpu_defines.sv
// Shared CPU definitions used by the sequential divider.
// Holds word types, the divider FSM state type, the divide step count and
// the control-level aliases used on start_i / ready_o.
package cpu_defines;

   typedef logic [31:0] Word_t;
   typedef logic [63:0] DWord_t;

   // Divider FSM states
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StDivZero = 2'd1,
      StOn      = 2'd2,
      StFinish  = 2'd3
   } div_state_e;

   // One quotient bit is produced per cycle
   localparam int unsigned DIV_CYCLES = 32;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (MIPS DIV / DIVU).
// One shift-subtract step per cycle on a 65-bit working register; operands
// are latched as magnitudes and the signs are fixed up when the result is
// registered.
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - asynchronous active-high reset
//   start_i      - divide request, held high until ready_o is seen
//   signed_i     - 1: signed (DIV), 0: unsigned (DIVU)
//   opdata1_i    - dividend
//   opdata2_i    - divisor
//   annul_i      - pipeline flush, cancels any operation in progress
//   result_o     - {remainder, quotient}
//   ready_o      - result_o valid
//   stall_req_o  - stall request to the pipeline controller
module div_seq
   import cpu_defines::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   start_i,
   input  logic   signed_i,
   input  Word_t  opdata1_i,
   input  Word_t  opdata2_i,
   input  logic   annul_i,
   output DWord_t result_o,
   output logic   ready_o,
   output logic   stall_req_o
);

   localparam int unsigned CntW = $clog2(DIV_CYCLES);

   div_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   // [64:32] partial remainder, [31:0] dividend bits shifting out / quotient bits in
   logic [64:0]     work_q, work_d;
   Word_t           divisor_q, divisor_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            ready_q, ready_d;
   DWord_t          result_q, result_d;

   Word_t       op1_abs, op2_abs;
   logic [64:0] shifted;
   logic [32:0] trial;
   Word_t       quo_fix, rem_fix;
   logic        unused_work_msb;

   always_comb begin
      op1_abs = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      op2_abs = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

      shifted = {work_q[63:0], 1'b0};
      trial   = shifted[64:32] - {1'b0, divisor_q};

      quo_fix = neg_quo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
      rem_fix = neg_rem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
   end

   // The partial remainder is always below the divisor between steps, so the
   // top bit of the working register stays clear.
   assign unused_work_msb = work_q[64];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      ready_d   = ready_q;
      result_d  = result_q;

      if (annul_i) begin
         state_d  = StIdle;
         cnt_d    = '0;
         ready_d  = DIV_RESULT_NOT_READY;
         result_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_d  = DIV_RESULT_NOT_READY;
               result_d = '0;
               cnt_d    = '0;
               if (start_i == DIV_START) begin
                  divisor_d = op2_abs;
                  work_d    = {33'd0, op1_abs};
                  neg_quo_d = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                  neg_rem_d = signed_i & opdata1_i[31];
                  state_d   = (opdata2_i == '0) ? StDivZero : StOn;
               end
            end
            StDivZero: begin
               if (start_i != DIV_START) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  // Zero magnitude with no sign fix-up yields a zero result
                  work_d    = '0;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = StFinish;
               end
            end
            StOn: begin
               if (start_i != DIV_START) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  // Restoring step: keep the subtraction only if it did not borrow
                  work_d = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
                  cnt_d  = cnt_q + 1'b1;
                  if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                     state_d = StFinish;
                  end
               end
            end
            StFinish: begin
               if (start_i == DIV_START) begin
                  ready_d  = DIV_RESULT_READY;
                  result_d = {rem_fix, quo_fix};
               end else begin
                  state_d  = StIdle;
                  cnt_d    = '0;
                  ready_d  = DIV_RESULT_NOT_READY;
                  result_d = '0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_q   <= DIV_RESULT_NOT_READY;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
      end
   end

   assign result_o    = result_q;
   assign ready_o     = ready_q;
   assign stall_req_o = start_i & ~ready_q;

endmodule
